// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states,
// instruction opcodes/functs and the datapath mux/ALU select codes.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        R_EXEC    = 4'd7,
        R_WB      = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        BRANCH    = 4'd11,
        JUMP      = 4'd12,
        JAL       = 4'd13,
        JR        = 4'd14,
        TRAP      = 4'd15
    } ctrlState_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;
    localparam logic [1:0] ALU_IMM   = 2'd3;

    localparam logic [1:0] SRCB_REG     = 2'd0;
    localparam logic [1:0] SRCB_FOUR    = 2'd1;
    localparam logic [1:0] SRCB_SIGNEXT = 2'd2;
    localparam logic [1:0] SRCB_SHIFTED = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;
    localparam logic [1:0] PCSRC_RS     = 2'd3;

    localparam logic [1:0] REGDST_RT = 2'd0;
    localparam logic [1:0] REGDST_RD = 2'd1;
    localparam logic [1:0] REGDST_RA = 2'd2;

    // Final state of each instruction class; leaving it retires the instruction.
    function automatic logic isLastState(input ctrlState_e s);
        return (s == MEM_WB) || (s == MEM_WRITE) || (s == R_WB) || (s == I_WB) ||
               (s == BRANCH) || (s == JUMP) || (s == JAL) || (s == JR);
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running 32-bit retired-instruction counter with enable and async clear.
module retire_counter (
    input  logic        clk,
    input  logic        clearN,
    input  logic        enable,
    output logic [31:0] count
);

    // Wraps naturally from all-ones back to zero.
    always_ff @(posedge clk or negedge clearN) begin
        if (!clearN)
            count <= 32'd0;
        else if (enable)
            count <= count + 32'd1;
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore-style control FSM for a multicycle MIPS datapath; all control
// outputs decode from the state register only.
module multicycle_control
    import mips_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_ne,
    output logic        iord,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  reg_dst,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        trap,
    output logic [3:0]  state,
    output logic [31:0] retired
);

    ctrlState_e currentState;
    ctrlState_e nextState;
    ctrlState_e boundaryState;
    logic       branchNeReg;
    logic       retireEn;

    // The bne/beq selector is captured at decode so BRANCH outputs stay state-only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            currentState <= IDLE;
            branchNeReg  <= 1'b0;
        end else begin
            currentState <= nextState;
            if (currentState == DECODE)
                branchNeReg <= opcode[0];
        end
    end

    always_comb begin
        boundaryState = run ? FETCH : IDLE;
        nextState     = currentState;
        case (currentState)
            IDLE:      if (run) nextState = FETCH;
            FETCH:     if (mem_ready) nextState = DECODE;
            DECODE: begin
                case (opcode)
                    OP_RTYPE:                         nextState = (funct == FUNCT_JR) ? JR : R_EXEC;
                    OP_LW, OP_SW:                     nextState = MEM_ADDR;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: nextState = I_EXEC;
                    OP_BEQ, OP_BNE:                   nextState = BRANCH;
                    OP_J:                             nextState = JUMP;
                    OP_JAL:                           nextState = JAL;
                    default:                          nextState = TRAP;
                endcase
            end
            MEM_ADDR:  nextState = (opcode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (mem_ready) nextState = MEM_WB;
            MEM_WRITE: if (mem_ready) nextState = boundaryState;
            R_EXEC:    nextState = R_WB;
            I_EXEC:    nextState = I_WB;
            MEM_WB, R_WB, I_WB, BRANCH, JUMP, JAL, JR: nextState = boundaryState;
            TRAP:      nextState = TRAP;
            default:   nextState = IDLE;
        endcase
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        reg_dst       = REGDST_RT;
        alu_src_b     = SRCB_REG;
        alu_op        = ALU_ADD;
        pc_source     = PCSRC_ALU;
        trap          = 1'b0;
        case (currentState)
            FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_FOUR;
            end
            DECODE:    alu_src_b = SRCB_SHIFTED;
            MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SIGNEXT;
            end
            MEM_READ: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            MEM_WRITE: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = REGDST_RD;
            end
            I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_SIGNEXT;
                alu_op    = ALU_IMM;
            end
            I_WB:      reg_write = 1'b1;
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                branch_ne     = branchNeReg;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            JAL: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                reg_write = 1'b1;
                reg_dst   = REGDST_RA;
            end
            JR: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_RS;
            end
            TRAP:      trap = 1'b1;
            default: ;
        endcase
    end

    // A store only retires once memory acknowledges it.
    assign retireEn = isLastState(currentState) && ((currentState != MEM_WRITE) || mem_ready);
    assign state    = currentState;

    retire_counter retireCounter (
        .clk    (clk),
        .clearN (reset),
        .enable (retireEn),
        .count  (retired)
    );

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: run in 1 (permit fetch); opcode in 6 and funct in 6 (from instruction register); mem_ready in 1 (memory access complete).
REQ-004 SHALL have outputs, 1 bit each unless stated:
- pc_write: unconditional PC load.
- pc_write_cond: conditional PC load.
- branch_ne: 0 = beq, 1 = bne.
- iord: 1 = address from ALUOut.
- mem_read, mem_write, ir_write, mem_to_reg, reg_write, alu_src_a.
- reg_dst[1:0]: 0 = rt, 1 = rd, 2 = $ra.
- alu_src_b[1:0]: 0 = reg, 1 = const 4, 2 = sign-extended immediate, 3 = immediate<<2.
- alu_op[1:0]: 0 = add, 1 = sub, 2 = funct, 3 = opcode-immediate.
- pc_source[1:0]: 0 = ALU, 1 = ALUOut, 2 = jump target, 3 = rs.
- trap: illegal opcode.
- state[3:0]: debug.
- retired[31:0]: instruction count.

Function
REQ-005 SHALL be a Moore FSM; every control output SHALL be a pure function of the state register.
REQ-006 States SHALL be: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP, JAL, JR, TRAP.
REQ-007 IDLE SHALL go to FETCH when run=1, else stay in IDLE; all IDLE outputs SHALL be 0.
REQ-008 FETCH SHALL assert mem_read, ir_write, pc_write, alu_src_b=1, alu_op=0, pc_source=0, iord=0, and SHALL hold all of them until mem_ready=1; PC and IR SHALL update only in the mem_ready cycle.
REQ-009 FETCH SHALL go to DECODE on mem_ready=1.
REQ-010 DECODE SHALL set alu_src_b=3, alu_op=0 (precompute branch target) and dispatch on opcode:
- 0x00 with funct 0x08 -> JR; other 0x00 -> R_EXEC.
- 0x23 or 0x2B -> MEM_ADDR.
- 0x08, 0x0C, 0x0D or 0x0F -> I_EXEC.
- 0x04 or 0x05 -> BRANCH.
- 0x02 -> JUMP; 0x03 -> JAL.
- any other opcode -> TRAP.
REQ-011 MEM_ADDR SHALL set alu_src_a=1, alu_src_b=2, alu_op=0, and go to MEM_READ (opcode 0x23) or MEM_WRITE (opcode 0x2B).
REQ-012 MEM_READ (mem_read=1, iord=1) and MEM_WRITE (mem_write=1, iord=1) SHALL hold until mem_ready=1; MEM_READ then goes to MEM_WB; MEM_WRITE then goes to the return state (REQ-016).
REQ-013 mem_write SHALL never be asserted outside MEM_WRITE, and mem_read SHALL never be asserted outside FETCH and MEM_READ.
REQ-014 Write-back and execute states SHALL drive:
- MEM_WB: reg_write, mem_to_reg, reg_dst=0.
- R_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2.
- R_WB: reg_write, reg_dst=1.
- I_EXEC: alu_src_a=1, alu_src_b=2, alu_op=3.
- I_WB: reg_write, reg_dst=0.
Each execute state SHALL be followed by its write-back state.
REQ-015 Control-transfer states SHALL drive:
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond, pc_source=1, branch_ne=opcode[0].
- JUMP: pc_write, pc_source=2.
- JAL: pc_write, pc_source=2, reg_write, reg_dst=2 (the datapath writes PC+4).
- JR: pc_write, pc_source=3, reg_write=0.
REQ-016 The last state of every instruction (MEM_WB, MEM_WRITE, R_WB, I_WB, BRANCH, JUMP, JAL, JR) SHALL:
- increment retired by 1, wrapping from 0xFFFFFFFF to 0;
- go to FETCH if run=1, else to IDLE.
REQ-017 Deasserting run mid-instruction SHALL NOT abort it; the FSM SHALL stop only at the instruction boundary.
REQ-018 TRAP SHALL set trap=1, assert no write enables, and remain in TRAP until reset.

Reset
REQ-019 On reset=0, asynchronously: state=IDLE, retired=0, and all outputs 0 (state output = IDLE encoding 4'd0).
REQ-020 Reset asserted during a memory wait SHALL drop mem_read/mem_write immediately.

Structure
REQ-021 State encodings, opcode/funct constants, and the alu_op/alu_src_b/pc_source/reg_dst codes SHALL reside in a shared package, mips_ctrl_pkg.
REQ-022 The retired counter SHALL be a sub-module, retire_counter (32-bit, enable, async active-low clear).

Verification
REQ-023 reset=0 then 1, run=0 for 5 cycles -> state=IDLE, all outputs 0, retired=0.
REQ-024 run=1, mem_ready=1, opcode 0x00 funct 0x20 -> FETCH, DECODE, R_EXEC, R_WB (reg_write=1, reg_dst=1) in 4 cycles; retired=1.
REQ-025 lw (0x23) with mem_ready held low for 3 cycles in MEM_READ -> mem_read=1 and iord=1 for 4 cycles; MEM_WB follows with mem_to_reg=1.
REQ-026 bne (0x05) -> BRANCH with pc_write_cond=1, branch_ne=1, alu_op=1; jal (0x03) -> JAL with reg_dst=2, pc_source=2.
REQ-027 opcode 0x3F -> TRAP, trap=1 held for 10 cycles with run=1; retired unchanged.
REQ-028 run dropped during R_EXEC -> R_WB completes, then IDLE; retired preloaded to 0xFFFFFFFF wraps to 0.
